// File: rtl/axi4lite_cmd_manager_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_cmd_manager_pkg
// Purpose  : Channel FSM state encoding and AXI response codes.
// Revision : 1.0 - initial release
// ============================================================================
package axi4lite_cmd_manager_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RDATA = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_RESP_DECERR = 2'b11;

  // States in which the manager is waiting on the subordinate.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_WRITE) || (s == ST_WRESP) || (s == ST_READ) || (s == ST_RDATA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4lite_cmd_manager_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_cmd_manager_if
// Purpose  : Command/response streams plus AXI4-Lite manager channels.
// Revision : 1.0 - initial release
// ============================================================================
interface axi4lite_cmd_manager_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]           cmd_wdata;
  logic [3:0]            cmd_wstrb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [31:0]           rsp_rdata;
  logic [1:0]            rsp_resp;
  logic                  timeout;

  logic                  m_axi_lite_awvalid;
  logic                  m_axi_lite_awready;
  logic [ADDR_WIDTH-1:0] m_axi_lite_awaddr;
  logic [2:0]            m_axi_lite_awprot;
  logic                  m_axi_lite_wvalid;
  logic                  m_axi_lite_wready;
  logic [31:0]           m_axi_lite_wdata;
  logic [3:0]            m_axi_lite_wstrb;
  logic                  m_axi_lite_bvalid;
  logic                  m_axi_lite_bready;
  logic [1:0]            m_axi_lite_bresp;
  logic                  m_axi_lite_arvalid;
  logic                  m_axi_lite_arready;
  logic [ADDR_WIDTH-1:0] m_axi_lite_araddr;
  logic [2:0]            m_axi_lite_arprot;
  logic                  m_axi_lite_rvalid;
  logic                  m_axi_lite_rready;
  logic [31:0]           m_axi_lite_rdata;
  logic [1:0]            m_axi_lite_rresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_resp, timeout,
    input  rsp_ready,
    output m_axi_lite_awvalid, m_axi_lite_awaddr, m_axi_lite_awprot,
    input  m_axi_lite_awready,
    output m_axi_lite_wvalid, m_axi_lite_wdata, m_axi_lite_wstrb,
    input  m_axi_lite_wready,
    input  m_axi_lite_bvalid, m_axi_lite_bresp,
    output m_axi_lite_bready,
    output m_axi_lite_arvalid, m_axi_lite_araddr, m_axi_lite_arprot,
    input  m_axi_lite_arready,
    input  m_axi_lite_rvalid, m_axi_lite_rdata, m_axi_lite_rresp,
    output m_axi_lite_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_resp, timeout,
    output rsp_ready,
    input  m_axi_lite_awvalid, m_axi_lite_awaddr, m_axi_lite_awprot,
    output m_axi_lite_awready,
    input  m_axi_lite_wvalid, m_axi_lite_wdata, m_axi_lite_wstrb,
    output m_axi_lite_wready,
    output m_axi_lite_bvalid, m_axi_lite_bresp,
    input  m_axi_lite_bready,
    input  m_axi_lite_arvalid, m_axi_lite_araddr, m_axi_lite_arprot,
    output m_axi_lite_arready,
    output m_axi_lite_rvalid, m_axi_lite_rdata, m_axi_lite_rresp,
    input  m_axi_lite_rready
  );
endinterface
`default_nettype wire

// File: rtl/axi4lite_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_watchdog
// Purpose  : Saturating wait counter with a sticky timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module axi4lite_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_timeout
);
  localparam logic [31:0] c_LIMIT   = 32'(TIMEOUT_CYCLES);
  localparam logic        c_ENABLED = (TIMEOUT_CYCLES != 0);

  logic [31:0] r_count;
  logic [31:0] w_count_next;
  logic        r_timeout;

  // Leaving the wait states restarts the count for the next transaction.
  always_comb begin
    w_count_next = '0;
    if (i_run && c_ENABLED) begin
      w_count_next = (r_count == c_LIMIT) ? r_count : r_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (c_ENABLED && (w_count_next == c_LIMIT)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: rtl/axi4lite_cmd_manager.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_cmd_manager
// Purpose  : Turns a command stream into single-beat AXI4-Lite transactions.
// Revision : 1.0 - initial release
// ============================================================================
module axi4lite_cmd_manager
  import axi4lite_cmd_manager_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   aclk,
  input  logic                   areset,
  axi4lite_cmd_manager_if.master bus
);
  state_t                r_state;
  state_t                w_next;
  logic                  r_cmd_ready;
  logic [ADDR_WIDTH-1:2] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_arvalid;
  logic                  r_rsp_write;
  logic [31:0]           r_rsp_rdata;
  logic [1:0]            r_rsp_resp;

  logic w_accept;
  logic w_aw_fire;
  logic w_w_fire;
  logic w_ar_fire;
  logic w_timeout;

  assign w_accept  = bus.cmd_valid && r_cmd_ready;
  assign w_aw_fire = r_awvalid && bus.m_axi_lite_awready;
  assign w_w_fire  = r_wvalid && bus.m_axi_lite_wready;
  assign w_ar_fire = r_arvalid && bus.m_axi_lite_arready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = bus.cmd_write ? ST_WRITE : ST_READ;
      // AW and W retire independently; leave once neither is still pending.
      ST_WRITE: if ((!r_awvalid || bus.m_axi_lite_awready) &&
                    (!r_wvalid  || bus.m_axi_lite_wready)) w_next = ST_WRESP;
      ST_WRESP: if (bus.m_axi_lite_bvalid) w_next = ST_RESP;
      ST_READ:  if (w_ar_fire) w_next = ST_RDATA;
      ST_RDATA: if (bus.m_axi_lite_rvalid) w_next = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      r_state     <= w_next;
      r_cmd_ready <= (w_next == ST_IDLE);
      if (w_accept) begin
        r_addr    <= bus.cmd_addr[ADDR_WIDTH-1:2];
        r_wdata   <= bus.cmd_wdata;
        r_wstrb   <= bus.cmd_wstrb;
        r_awvalid <= bus.cmd_write;
        r_wvalid  <= bus.cmd_write;
        r_arvalid <= !bus.cmd_write;
      end else begin
        if (w_aw_fire) r_awvalid <= 1'b0;
        if (w_w_fire)  r_wvalid  <= 1'b0;
        if (w_ar_fire) r_arvalid <= 1'b0;
      end
      if ((r_state == ST_WRESP) && bus.m_axi_lite_bvalid) begin
        r_rsp_write <= 1'b1;
        r_rsp_rdata <= '0;
        r_rsp_resp  <= bus.m_axi_lite_bresp;
      end
      if ((r_state == ST_RDATA) && bus.m_axi_lite_rvalid) begin
        r_rsp_write <= 1'b0;
        r_rsp_rdata <= bus.m_axi_lite_rdata;
        r_rsp_resp  <= bus.m_axi_lite_rresp;
      end
    end
  end

  axi4lite_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (aclk),
    .rst       (areset),
    .i_run     (is_wait_state(r_state)),
    .o_timeout (w_timeout)
  );

  assign bus.cmd_ready          = r_cmd_ready;
  assign bus.rsp_valid          = (r_state == ST_RESP);
  assign bus.rsp_write          = r_rsp_write;
  assign bus.rsp_rdata          = r_rsp_rdata;
  assign bus.rsp_resp           = r_rsp_resp;
  assign bus.timeout            = w_timeout;

  assign bus.m_axi_lite_awvalid = r_awvalid;
  assign bus.m_axi_lite_awaddr  = {r_addr, 2'b00};
  assign bus.m_axi_lite_awprot  = 3'b000;
  assign bus.m_axi_lite_wvalid  = r_wvalid;
  assign bus.m_axi_lite_wdata   = r_wdata;
  assign bus.m_axi_lite_wstrb   = r_wstrb;
  assign bus.m_axi_lite_bready  = (r_state == ST_WRESP);
  assign bus.m_axi_lite_arvalid = r_arvalid;
  assign bus.m_axi_lite_araddr  = {r_addr, 2'b00};
  assign bus.m_axi_lite_arprot  = 3'b000;
  assign bus.m_axi_lite_rready  = (r_state == ST_RDATA);

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_cmd_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4lite_cmd_manager
// Purpose  : Scoreboard bench with a behavioural register subordinate.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4lite_cmd_manager;
  import axi4lite_cmd_manager_pkg::*;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi4lite_cmd_manager_if #(.ADDR_WIDTH(32)) bus ();

  axi4lite_cmd_manager #(
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t exp_q[$];

  // subordinate model configuration and state
  logic [31:0] mem [logic [31:0]];
  int          aw_lat = 0, w_lat = 0, aw_wait = 0, w_wait = 0;
  bit          b_never = 0, rerr = 0;
  logic [1:0]  bresp_cfg = c_RESP_OKAY;
  logic [31:0] rerr_data = 32'h0;
  logic [1:0]  rerr_resp = c_RESP_OKAY;
  bit          aw_got, w_got, ar_got, aw_fire, w_fire, b_fire, ar_fire, r_fire;
  bit          aw_pend, w_pend, ar_pend;
  logic [31:0] aw_addr_q, w_data_q, ar_addr_q, aw_prev, w_prev, ar_prev;
  logic [3:0]  w_strb_q;
  int          aw_beats = 0, w_beats = 0, b_beats = 0, rsp_count = 0;
  logic [31:0] exp_bus_addr = 32'h0, exp_wdata = 32'h0;
  logic [3:0]  exp_wstrb = 4'h0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = mem_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
    mem[a] = v;
  endtask

  // Subordinate: drives at negedge; fire flags describe the coming posedge.
  initial begin
    bus.m_axi_lite_awready = 1'b0; bus.m_axi_lite_wready = 1'b0;
    bus.m_axi_lite_bvalid  = 1'b0; bus.m_axi_lite_bresp  = 2'b00;
    bus.m_axi_lite_arready = 1'b0; bus.m_axi_lite_rvalid = 1'b0;
    bus.m_axi_lite_rdata   = 32'h0; bus.m_axi_lite_rresp = 2'b00;
    forever begin
      @(negedge aclk);
      if (areset) begin
        {aw_got, w_got, ar_got, aw_fire, w_fire, b_fire, ar_fire, r_fire} = '0;
        {aw_pend, w_pend, ar_pend} = '0;
        aw_wait = 0; w_wait = 0;
        bus.m_axi_lite_awready = 1'b0; bus.m_axi_lite_wready = 1'b0;
        bus.m_axi_lite_bvalid  = 1'b0; bus.m_axi_lite_arready = 1'b0;
        bus.m_axi_lite_rvalid  = 1'b0;
      end else begin
        if (aw_pend) begin
          chk("aw_hold", 32'(bus.m_axi_lite_awvalid), 1);
          chk("aw_stable", bus.m_axi_lite_awaddr, aw_prev);
        end
        if (w_pend) begin
          chk("w_hold", 32'(bus.m_axi_lite_wvalid), 1);
          chk("w_stable", bus.m_axi_lite_wdata, w_prev);
        end
        if (ar_pend) begin
          chk("ar_hold", 32'(bus.m_axi_lite_arvalid), 1);
          chk("ar_stable", bus.m_axi_lite_araddr, ar_prev);
        end
        if (aw_fire) aw_got = 1;
        if (w_fire)  w_got  = 1;
        if (b_fire) begin bus.m_axi_lite_bvalid = 1'b0; aw_got = 0; w_got = 0; end
        if (ar_fire) ar_got = 1;
        if (r_fire) begin bus.m_axi_lite_rvalid = 1'b0; ar_got = 0; end

        bus.m_axi_lite_awready = 1'b0;
        if (bus.m_axi_lite_awvalid && !aw_got) begin
          if (aw_wait >= aw_lat) bus.m_axi_lite_awready = 1'b1; else aw_wait++;
        end
        bus.m_axi_lite_wready = 1'b0;
        if (bus.m_axi_lite_wvalid && !w_got) begin
          if (w_wait >= w_lat) bus.m_axi_lite_wready = 1'b1; else w_wait++;
        end
        bus.m_axi_lite_arready = bus.m_axi_lite_arvalid && !ar_got;

        if (aw_got && w_got && !bus.m_axi_lite_bvalid && !b_never) begin
          mem_wr(aw_addr_q, w_data_q, w_strb_q);
          bus.m_axi_lite_bvalid = 1'b1;
          bus.m_axi_lite_bresp  = bresp_cfg;
        end
        if (ar_got && !bus.m_axi_lite_rvalid) begin
          bus.m_axi_lite_rvalid = 1'b1;
          bus.m_axi_lite_rdata  = rerr ? rerr_data : mem_rd(ar_addr_q);
          bus.m_axi_lite_rresp  = rerr ? rerr_resp : c_RESP_OKAY;
        end

        if (bus.m_axi_lite_bready) chk("bready_early", 32'(aw_got && w_got), 1);
        if (bus.m_axi_lite_rready) chk("rready_early", 32'(ar_got), 1);

        aw_fire = bus.m_axi_lite_awvalid && bus.m_axi_lite_awready;
        w_fire  = bus.m_axi_lite_wvalid && bus.m_axi_lite_wready;
        b_fire  = bus.m_axi_lite_bvalid && bus.m_axi_lite_bready;
        ar_fire = bus.m_axi_lite_arvalid && bus.m_axi_lite_arready;
        r_fire  = bus.m_axi_lite_rvalid && bus.m_axi_lite_rready;
        if (aw_fire) begin
          aw_beats++; aw_wait = 0; aw_addr_q = bus.m_axi_lite_awaddr;
          chk("awaddr", bus.m_axi_lite_awaddr, exp_bus_addr);
          chk("awprot", 32'(bus.m_axi_lite_awprot), 0);
        end
        if (w_fire) begin
          w_beats++; w_wait = 0;
          w_data_q = bus.m_axi_lite_wdata; w_strb_q = bus.m_axi_lite_wstrb;
          chk("wdata", bus.m_axi_lite_wdata, exp_wdata);
          chk("wstrb", 32'(bus.m_axi_lite_wstrb), 32'(exp_wstrb));
        end
        if (b_fire) b_beats++;
        if (ar_fire) begin
          ar_addr_q = bus.m_axi_lite_araddr;
          chk("araddr", bus.m_axi_lite_araddr, exp_bus_addr);
          chk("arprot", 32'(bus.m_axi_lite_arprot), 0);
        end
        aw_pend = bus.m_axi_lite_awvalid && !aw_fire; aw_prev = bus.m_axi_lite_awaddr;
        w_pend  = bus.m_axi_lite_wvalid && !w_fire;   w_prev  = bus.m_axi_lite_wdata;
        ar_pend = bus.m_axi_lite_arvalid && !ar_fire; ar_prev = bus.m_axi_lite_araddr;
      end
    end
  end

  // Response monitor: pops the scoreboard on each rsp handshake.
  bit          rsp_pend = 0;
  logic        rsp_wr_prev;
  logic [31:0] rsp_rd_prev;
  logic [1:0]  rsp_resp_prev;
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (areset) begin
        exp_q.delete();
        rsp_pend = 0;
      end else begin
        if (rsp_pend) begin
          chk("rsp_hold", 32'(bus.rsp_valid), 1);
          chk("rsp_write_stable", 32'(bus.rsp_write), 32'(rsp_wr_prev));
          chk("rsp_rdata_stable", bus.rsp_rdata, rsp_rd_prev);
          chk("rsp_resp_stable", 32'(bus.rsp_resp), 32'(rsp_resp_prev));
        end
        rsp_pend = 0;
        if (bus.rsp_valid && bus.rsp_ready) begin
          rsp_count++;
          chk("rsp_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_write", 32'(bus.rsp_write), 32'(e.wr));
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_resp", 32'(bus.rsp_resp), 32'(e.resp));
          end
        end else if (bus.rsp_valid) begin
          rsp_pend = 1;
          rsp_wr_prev = bus.rsp_write; rsp_rd_prev = bus.rsp_rdata; rsp_resp_prev = bus.rsp_resp;
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [31:0] erd, input logic [1:0] eresp);
    int   n = 0;
    exp_t e;
    exp_bus_addr = {addr[31:2], 2'b00};
    exp_wdata = wd;
    exp_wstrb = ws;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
    bus.cmd_wdata = wd;   bus.cmd_wstrb = ws;
    while (!bus.cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_accept_wait", 32'(n < 50), 1);
    e.wr = wr; e.rdata = wr ? 32'h0 : erd; e.resp = eresp;
    exp_q.push_back(e);
    tick();
    bus.cmd_valid = 1'b0;
    chk("cmd_ready_busy", 32'(bus.cmd_ready), 0);
    chk(wr ? "aw_w_latency" : "ar_latency",
        32'({bus.m_axi_lite_awvalid, bus.m_axi_lite_wvalid, bus.m_axi_lite_arvalid}),
        wr ? 32'h6 : 32'h1);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.cmd_ready) && n < 100) begin tick(); n++; end
    chk("done_wait", 32'(n < 100), 1);
  endtask

  initial begin
    int aw0, w0, b0, r0, n;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0;
    bus.cmd_wdata = 32'h0; bus.cmd_wstrb = 4'h0; bus.rsp_ready = 1'b1;
    areset = 1'b1;
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("rst_valids", 32'({bus.m_axi_lite_awvalid, bus.m_axi_lite_wvalid, bus.m_axi_lite_arvalid,
                           bus.m_axi_lite_bready, bus.m_axi_lite_rready, bus.rsp_valid}), 0);
    chk("rst_addr", bus.m_axi_lite_awaddr | bus.m_axi_lite_araddr | bus.m_axi_lite_wdata, 0);
    chk("rst_rsp", 32'({bus.rsp_write, bus.rsp_resp, bus.timeout}), 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    areset = 1'b0;
    tick();
    chk("cmd_ready_after_rst", 32'(bus.cmd_ready), 1);

    // write then read back, with best-case latency check
    send(1'b1, 32'h104, 32'h10, 4'hF, 32'h0, c_RESP_OKAY);
    tick();
    chk("bready_t2", 32'({bus.m_axi_lite_bready, bus.rsp_valid}), 32'h2);
    tick();
    chk("rsp_valid_t3", 32'(bus.rsp_valid), 1);
    wait_done();
    chk("t1_beats", 32'({aw_beats[3:0], w_beats[3:0], b_beats[3:0]}), 32'h111);
    send(1'b0, 32'h104, 32'h0, 4'h0, 32'h10, c_RESP_OKAY);
    wait_done();

    // W accepted three cycles before AW
    aw0 = aw_beats; w0 = w_beats; b0 = b_beats; r0 = rsp_count;
    aw_lat = 3;
    send(1'b1, 32'h10C, 32'h1234_5678, 4'hF, 32'h0, c_RESP_OKAY);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w_early_aw_held", 32'({bus.m_axi_lite_awvalid, bus.m_axi_lite_wvalid}), 32'h2);
    end
    wait_done();
    aw_lat = 0;
    chk("t2_aw_beats", 32'(aw_beats - aw0), 1);
    chk("t2_w_beats", 32'(w_beats - w0), 1);
    chk("t2_b_beats", 32'(b_beats - b0), 1);
    chk("t2_rsp_count", 32'(rsp_count - r0), 1);

    // error responses pass straight through
    rerr = 1; rerr_data = 32'hDEAD_BEEF; rerr_resp = c_RESP_SLVERR;
    send(1'b0, 32'h200, 32'h0, 4'h0, 32'hDEAD_BEEF, c_RESP_SLVERR);
    wait_done();
    rerr = 0;
    bresp_cfg = c_RESP_DECERR;
    send(1'b1, 32'h108, 32'hAABB_CCDD, 4'h3, 32'h0, c_RESP_DECERR);
    wait_done();
    bresp_cfg = c_RESP_OKAY;
    send(1'b0, 32'h108, 32'h0, 4'h0, 32'h0000_CCDD, c_RESP_OKAY);
    wait_done();

    // unaligned command address
    send(1'b0, 32'h107, 32'h0, 4'h0, 32'h10, c_RESP_OKAY);
    wait_done();

    // response back-pressure
    bus.rsp_ready = 1'b0;
    send(1'b0, 32'h10C, 32'h0, 4'h0, 32'h1234_5678, c_RESP_OKAY);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin tick(); n++; end
    chk("stall_rsp_wait", 32'(n < 20), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("stall_cmd_ready", 32'(bus.cmd_ready), 0);
      chk("stall_rdata", bus.rsp_rdata, 32'h1234_5678);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("cmd_ready_after_rsp", 32'(bus.cmd_ready), 1);
    send(1'b0, 32'h104, 32'h0, 4'h0, 32'h10, c_RESP_OKAY);
    wait_done();
    chk("no_timeout_yet", 32'(bus.timeout), 0);

    // watchdog with a subordinate that never answers B
    b_never = 1;
    send(1'b1, 32'h110, 32'h55, 4'hF, 32'h0, c_RESP_OKAY);
    for (int i = 0; i < 8; i++) begin
      chk("timeout_early", 32'(bus.timeout), 0);
      tick();
    end
    chk("timeout_set", 32'(bus.timeout), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("timeout_sticky", 32'({bus.timeout, bus.m_axi_lite_bready}), 32'h3);
    end
    areset = 1'b1;
    tick();
    chk("rst_mid_valids", 32'({bus.m_axi_lite_awvalid, bus.m_axi_lite_wvalid, bus.m_axi_lite_arvalid,
                               bus.m_axi_lite_bready, bus.m_axi_lite_rready, bus.rsp_valid}), 0);
    chk("rst_mid_timeout", 32'(bus.timeout), 0);
    chk("rst_mid_cmd_ready", 32'(bus.cmd_ready), 0);
    b_never = 0;
    areset = 1'b0;
    tick();
    chk("cmd_ready_after_rst2", 32'(bus.cmd_ready), 1);
    send(1'b0, 32'h104, 32'h0, 4'h0, 32'h10, c_RESP_OKAY);
    wait_done();
    chk("timeout_after_rst", 32'(bus.timeout), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/axi4lite_cmd_manager.md
Name: axi4lite_cmd_manager

Overview:
- AXI4-Lite manager (initiator) that turns a simple command stream into single-beat AXI4-Lite register reads and writes.
- Returns each result on a response stream.
- Sits between the PS-side or local control logic and register subordinates such as the ADC trigger block, for example to program its divider and config registers.
- At most one transaction is outstanding at any time.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and the AXI address channels.
- TIMEOUT_CYCLES, 1024, number of cycles a transaction may wait on the bus before the timeout flag is raised; 0 disables the watchdog.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echoes cmd_write of the completed transaction.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as received.
- timeout  out  1  sticky watchdog flag.
- m_axi_lite_aw*/w*/b*/ar*/r*  standard AXI4-Lite manager channels; addr ADDR_WIDTH, data 32, strb 4, prot 3.

Behaviour:
- Reset: synchronous, active-high, applied on a rising aclk edge.
  - Outputs: cmd_ready=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_resp=0, timeout=0.
  - All AXI valid/ready outputs 0; AXI address/data outputs 0.
  - State = IDLE on the first edge after reset deasserts.
- cmd_ready=1 only in IDLE. A command is accepted on the edge where cmd_valid && cmd_ready.
  - On acceptance, addr, wdata, wstrb and write are registered.
  - addr[1:0] is forced to 0 on the bus.
  - awprot/arprot = 3'b000.
- States: IDLE, WRITE, WRESP, READ, RDATA, RESP.
  - IDLE -> WRITE on an accepted write, with awvalid and wvalid both 1 in the next cycle (one-cycle latency).
  - IDLE -> READ on an accepted read, with arvalid=1 in the next cycle.
  - WRITE: awvalid drops on the edge after awready; wvalid drops on the edge after wready. The two handshakes are tracked independently in any order, including the same cycle. Exit to WRESP once both have completed.
  - WRESP: bready=1. On bvalid, capture bresp, set rsp_rdata=0 and rsp_write=1, then go to RESP.
  - READ: arvalid held until arready, then go to RDATA.
  - RDATA: rready=1. On rvalid, capture rdata and rresp, set rsp_write=0, then go to RESP.
  - RESP: rsp_valid=1 and the response fields are held stable until rsp_ready. Then go to IDLE with cmd_ready=1 in the next cycle.
- Ready outputs: bready and rready are 1 only in WRESP and RDATA respectively, never earlier.
- AXI valid rule: an asserted valid is never withdrawn before its handshake, and its payload never changes while valid.
- Best-case write: cmd accepted at T; aw/w valid T+1; bready T+2. If bvalid arrives at T+2, rsp_valid is high at T+3.
- Watchdog:
  - A 32-bit counter clears in IDLE and RESP.
  - It increments each cycle spent in WRITE, WRESP, READ or RDATA, saturating at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES sets timeout=1. timeout is sticky until areset.
  - The transaction is not aborted and continues waiting.
  - The counter restarts for each transaction.
- rsp_resp is passed through unchanged. SLVERR (2'b10) and DECERR (2'b11) produce no other side effect.
- Reset mid-transaction: all valids drop on the reset edge and the pending command is discarded. The subordinate must be reset in the same domain.

Decomposition:
- Shared package: state encodings; AXI response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
- The existing write-strobe helper include is not needed.
- One natural sub-module: axi4lite_watchdog, containing the counter, the saturate logic and the sticky flag.
- The channel FSM stays in the top module.

Test Plan:
- Write addr 0x104, data 0x0000_0010, strb 0xF to an ADC trigger subordinate. Required: one AW+W beat with awaddr=0x104; rsp_valid with rsp_write=1, rsp_resp=00; a subsequent read of 0x104 returns rsp_rdata=0x10.
- Subordinate accepts W three cycles before AW. Required: wvalid drops after wready; awvalid stays held; exactly one B is accepted; exactly one response is produced.
- Read of unmapped addr 0x200 while the subordinate returns RRESP=10. Required: rsp_resp=2'b10, rsp_rdata as driven, rsp_write=0.
- Command issued with cmd_addr=0x107. Required: araddr=0x104 on the bus.
- rsp_ready held low for 5 cycles. Required: rsp_valid and the response fields stay stable; cmd_ready stays 0; the next command is accepted the cycle after rsp_ready plus one.
- TIMEOUT_CYCLES=8, with a subordinate that never asserts bvalid. Required: timeout=1 after 8 waiting cycles and stays 1. areset mid-wait then clears all valids and timeout on the next edge, and cmd_ready=1 one cycle after reset deasserts.
